rcv_timer: RTL
==============

Name: rcv_timer

Overview:
- Bit-timing unit of the serial receiver. It sits between the receive control FSM, which drives enable_timer, and the shift register and stop-bit checker, which consume shift_strobe.
- Counts system clocks across one frame, pulses shift_strobe at the centre of each data and stop bit, and pulses packet_done once the frame has been fully sampled.
- Runs only while enable_timer is high. Dropping enable_timer aborts the frame.

Parameters:
- CLKS_PER_BIT, 10, system clocks per serial bit; must be >= 4.
- DATA_BITS, 8, data bits per frame; range 5..9.
- START_OFFSET, 13, enabled cycle index of the first sample strobe (1.5 bit periods minus detector/clear latency); must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset.
- enable_timer  input  1  frame timing enable from the receive control FSM.
- shift_strobe  output  1  one-cycle pulse at bit centre; the shift register samples serial_in in this cycle.
- bit_index  output  4  index of the bit being strobed (0 = first data bit); valid only while shift_strobe is high, 0 otherwise.
- packet_done  output  1  one-cycle pulse one cycle after the final (stop-bit) strobe.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: while rst is high at a rising edge, the state goes to IDLE and all counters clear. All outputs read 0 from the following cycle.
- Derived constants:
  - NBITS = DATA_BITS + 1 (data plus stop).
  - LAST = START_OFFSET + (NBITS-1)*CLKS_PER_BIT.
- Enabled-cycle numbering: cycle n is the n-th consecutive cycle (n from 0) in which enable_timer is high. The internal cycle counter holds n during cycle n.
- States:
  - IDLE: counter = 0. Moves to RUN on any edge where enable_timer is high. Cycle 0 is itself evaluated in IDLE, with counter 0.
  - RUN: the counter increments every enabled cycle. A strobe fires in cycle n iff n = START_OFFSET + k*CLKS_PER_BIT for k = 0..NBITS-1, with bit_index = k.
    - Implementation: a bit-period sub-counter plus a bit counter, not a full-frame comparator. Widths are $clog2-sized.
  - After the strobe at n = LAST, the state moves to DONE.
  - DONE: packet_done = 1 for exactly one cycle (cycle LAST+1), then HOLD.
  - HOLD: all outputs 0. Stays in HOLD while enable_timer is high; no further strobes occur.
- Outputs are Moore decodes of the registered state and counters, ANDed with enable_timer. Every output is 0 in any cycle where enable_timer is low.
- Abort: enable_timer low at any edge returns the FSM to IDLE with counters cleared. The next high starts a fresh frame at cycle 0, with no residue from the aborted frame.
- Simultaneous rst and enable_timer: rst wins.
- Cycle-0 strobe: START_OFFSET = 0 is illegal. An elaboration-time assertion checks START_OFFSET >= 1, CLKS_PER_BIT >= 4 and DATA_BITS in 5..9.
- Counters never wrap within a frame: the sub-counter wraps at CLKS_PER_BIT-1 to 0, and the bit counter saturates at NBITS-1.

Optional Feature:
- Macro: RCV_TIMER_PARITY_EN.
- Defined:
  - NBITS = DATA_BITS + 2, with slot order data, parity, stop.
  - Adds output parity_strobe (1 bit), high coincident with shift_strobe when bit_index = DATA_BITS.
  - LAST and packet_done shift later by one CLKS_PER_BIT.
- Undefined:
  - No parity_strobe port.
  - NBITS = DATA_BITS + 1.

Test Plan:
- Nominal frame (defaults), rst released, enable_timer high from cycle 0 onward:
  - 9 shift_strobe pulses at cycles 13, 23, ..., 93, with bit_index 0..8.
  - packet_done high only at cycle 94.
  - All outputs 0 through cycle 200.
- Abort: enable_timer high for cycles 0..40, low at 41, high again from 50:
  - Strobes at 13, 23, 33.
  - Nothing during 41..49.
  - New frame strobes at 63, 73, ..., with packet_done at 144.
- Reset mid-frame: rst high at cycle 30 while enable_timer stays high:
  - Outputs 0 at cycle 31.
  - After rst drops at 31, the frame restarts; the first strobe is 13 enabled cycles later.
- Back-to-back frames: enable_timer low for exactly one cycle after packet_done, then high again → the second frame timing is identical to the first (strobe 13 cycles after re-enable).
- Parameter sweep, CLKS_PER_BIT=16, DATA_BITS=5, START_OFFSET=22 → strobes at 22, 38, 54, 70, 86, 102; packet_done at 103.
- RCV_TIMER_PARITY_EN defined (defaults):
  - 10 strobes, the last at 103.
  - parity_strobe only at cycle 93 (bit_index 8).
  - packet_done at 104.

Source files
------------

// File: rtl/rcv_timer_if.sv
// Bit-timing bus between the receive control FSM and the receive data path.
// With RCV_TIMER_PARITY_EN defined the bus also carries parity_strobe.
interface rcv_timer_if;
  logic       enable_timer;
  logic       shift_strobe;
  logic [3:0] bit_index;
  logic       packet_done;
`ifdef RCV_TIMER_PARITY_EN
  logic       parity_strobe;

  modport slave (
    input  enable_timer,
    output shift_strobe,
    output bit_index,
    output packet_done,
    output parity_strobe
  );

  modport master (
    output enable_timer,
    input  shift_strobe,
    input  bit_index,
    input  packet_done,
    input  parity_strobe
  );
`else
  modport slave (
    input  enable_timer,
    output shift_strobe,
    output bit_index,
    output packet_done
  );

  modport master (
    output enable_timer,
    input  shift_strobe,
    input  bit_index,
    input  packet_done
  );
`endif
endinterface

// File: rtl/rcv_timer.sv
// Receiver bit timer: strobes each data/stop bit centre, then pulses packet_done.
// Optional RCV_TIMER_PARITY_EN adds a parity slot between data and stop bits.
//
// state | meaning
// IDLE  | no frame in progress, counters clear; first enabled cycle is cycle 0
// RUN   | counting enabled cycles, strobing bit centres
// DONE  | final strobe seen; packet_done asserted this cycle
// HOLD  | frame complete, outputs quiet until enable_timer drops
module rcv_timer #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8,
  parameter int START_OFFSET = 13
) (
  input  logic        clk,
  input  logic        rst,
  rcv_timer_if.slave  tmr
);

`ifdef RCV_TIMER_PARITY_EN
  localparam int NBITS = DATA_BITS + 2;
`else
  localparam int NBITS = DATA_BITS + 1;
`endif
  localparam int SUB_MAX = (START_OFFSET > CLKS_PER_BIT - 1) ? START_OFFSET : CLKS_PER_BIT - 1;
  localparam int SUB_W   = $clog2(SUB_MAX + 1);
  localparam int BIT_W   = $clog2(NBITS);

  if (START_OFFSET < 1 || CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9) begin : g_param_err
    $error("rcv_timer: illegal parameter set");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE, HOLD} state_t;

  state_t             r_state;
  logic [SUB_W-1:0]   r_sub;
  logic               r_lead;
  logic [BIT_W-1:0]   r_bit;

  logic w_tc;
  logic w_last;
  logic w_strobe;

  // Before the first strobe r_sub tracks the enabled-cycle index directly;
  // afterwards it is a bit-period phase that hits 0 at each bit centre.
  assign w_tc     = r_lead ? (r_sub == SUB_W'(START_OFFSET)) : (r_sub == '0);
  assign w_last   = (r_bit == BIT_W'(NBITS - 1));
  assign w_strobe = tmr.enable_timer && (r_state == RUN) && w_tc;

  always_ff @(posedge clk) begin
    if (rst || !tmr.enable_timer) begin
      r_state <= IDLE;
      r_sub   <= '0;
      r_lead  <= 1'b1;
      r_bit   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= RUN;
          r_sub   <= SUB_W'(1);
          r_lead  <= 1'b1;
          r_bit   <= '0;
        end
        RUN: begin
          if (w_tc) begin
            r_lead <= 1'b0;
            r_sub  <= SUB_W'(1);
            if (w_last) r_state <= DONE;
            else        r_bit   <= r_bit + BIT_W'(1);
          end else if (!r_lead && r_sub == SUB_W'(CLKS_PER_BIT - 1)) begin
            r_sub <= '0;
          end else begin
            r_sub <= r_sub + SUB_W'(1);
          end
        end
        DONE:    r_state <= HOLD;
        HOLD:    r_state <= HOLD;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tmr.shift_strobe = w_strobe;
  assign tmr.bit_index    = w_strobe ? 4'(r_bit) : 4'd0;
  assign tmr.packet_done  = tmr.enable_timer && (r_state == DONE);
`ifdef RCV_TIMER_PARITY_EN
  assign tmr.parity_strobe = w_strobe && (r_bit == BIT_W'(DATA_BITS));
`endif

endmodule
